// File: rtl/flag_unit.sv
// Condition-flag producer: captures ALU results, derives {Z,V,N}, and commits them
// through a two-stage pending/commit pipeline. Define FLAG_BYPASS_EN to forward pending flags.
module flag_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             alu_valid,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ovfl,
  input  logic             br_query,
  output logic [2:0]       flags,
  output logic             flags_busy,
  output logic             br_stall
);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_XOR = 4'b0010,
    OP_SLL = 4'b0100,
    OP_SRA = 4'b0101,
    OP_ROR = 4'b0110
  } flag_op_e;

  // Bit positions in every 3-bit flag vector: {Z, V, N}.
  logic [2:0] flags_q;
  logic [2:0] pend_mask;
  logic [2:0] pend_vals;
  logic       pend_valid;
  logic [2:0] cur_mask;
  logic [2:0] cur_vals;
  logic [2:0] merged;
  logic       wr;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    cur_mask = 3'b000;
    case (alu_op)
      OP_ADD, OP_SUB:                 cur_mask = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: cur_mask = 3'b100;
      default:                        cur_mask = 3'b000;
    endcase
  end

  assign cur_vals = {(alu_result == '0), alu_ovfl, alu_result[WIDTH-1]};
  assign wr       = alu_valid && (cur_mask != 3'b000) && !flush;
  assign merged   = (flags_q & ~pend_mask) | (pend_vals & pend_mask);

  // NOTE: reset is sampled on the clock edge (synchronous), and all state uses
  // non-blocking assignments so commit and capture see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q    <= 3'b000;
      pend_valid <= 1'b0;
      pend_mask  <= 3'b000;
      pend_vals  <= 3'b000;
    end else if (flush) begin
      // Flush outranks stall: drop the pending update, commit nothing, capture nothing.
      pend_valid <= 1'b0;
    end else if (!stall) begin
      if (pend_valid) flags_q <= merged;
      pend_valid <= wr;
      if (wr) begin
        pend_mask <= cur_mask;
        pend_vals <= cur_vals;
      end
    end
  end

  assign flags_busy = pend_valid;

`ifdef FLAG_BYPASS_EN
  assign flags    = pend_valid ? merged : flags_q;
  assign br_stall = br_query && alu_valid && (cur_mask != 3'b000);
`else
  assign flags    = flags_q;
  assign br_stall = br_query && (pend_valid || (alu_valid && (cur_mask != 3'b000)));
`endif

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: directed vector table plus randomized traffic
// compared against a queue-based model of pending flag updates.
module tb_flag_unit;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n, stall, flush, alu_valid, alu_ovfl, br_query;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic [2:0]       flags;
  logic             flags_busy, br_stall;

  int n_tests = 0;
  int n_fail  = 0;

  flag_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_result(alu_result),
    .alu_ovfl(alu_ovfl), .br_query(br_query),
    .flags(flags), .flags_busy(flags_busy), .br_stall(br_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic             rst_n, stall, flush, valid;
    logic [3:0]       op;
    logic [WIDTH-1:0] res;
    logic             ovfl, q, chk;
    logic [2:0]       ef;
    logic             eb, es;
    logic [2:0]       efb;
    logic             esb;
  } vec_t;

  typedef struct {
    logic [2:0] mask;
    logic [2:0] vals;
  } upd_t;

  vec_t vecs[$];

  // Reference model: architectural flags plus a queue of in-flight updates.
  logic [2:0] m_flags = 3'b000;
  upd_t       m_pend[$];

  function automatic logic [2:0] op_mask(input logic [3:0] op);
    if (op inside {4'd0, 4'd1})             return 3'b111;
    if (op inside {4'd2, 4'd4, 4'd5, 4'd6}) return 3'b100;
    return 3'b000;
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic v(input string name, input logic r, s, f, va, input logic [3:0] op,
                   input logic [WIDTH-1:0] res, input logic ov, q, chk,
                   input logic [2:0] ef, input logic eb, es,
                   input logic [2:0] efb, input logic esb);
    vec_t t;
    t.name = name; t.rst_n = r; t.stall = s; t.flush = f; t.valid = va;
    t.op = op; t.res = res; t.ovfl = ov; t.q = q; t.chk = chk;
    t.ef = ef; t.eb = eb; t.es = es; t.efb = efb; t.esb = esb;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic r, s, f, va, input logic [3:0] op,
                       input logic [WIDTH-1:0] res, input logic ov, q);
    rst_n = r; stall = s; flush = f; alu_valid = va;
    alu_op = op; alu_result = res; alu_ovfl = ov; br_query = q;
  endtask

  // Compare against the model while inputs are stable, then advance the model across the edge.
  task automatic model_cycle(input bit compare);
    logic [2:0] mask, vals, exp_f;
    logic       busy, wr_any, exp_s;
    upd_t       u;
    mask   = op_mask(alu_op);
    vals   = {(alu_result == 0), alu_ovfl, alu_result[WIDTH-1]};
    busy   = (m_pend.size() != 0);
    wr_any = alu_valid && (mask != 0);
`ifdef FLAG_BYPASS_EN
    exp_f = busy ? ((m_flags & ~m_pend[0].mask) | (m_pend[0].vals & m_pend[0].mask)) : m_flags;
    exp_s = br_query && wr_any;
`else
    exp_f = m_flags;
    exp_s = br_query && (busy || wr_any);
`endif
    if (compare) begin
      check("rnd_flags", flags, exp_f);
      check("rnd_busy", {2'b00, flags_busy}, {2'b00, busy});
      check("rnd_br_stall", {2'b00, br_stall}, {2'b00, exp_s});
    end
    if (!rst_n) begin
      m_flags = 3'b000;
      m_pend.delete();
    end else if (flush) begin
      m_pend.delete();
    end else if (!stall) begin
      if (m_pend.size() != 0) begin
        u = m_pend.pop_front();
        for (int i = 0; i < 3; i++) if (u.mask[i]) m_flags[i] = u.vals[i];
      end
      if (wr_any) begin
        u.mask = mask;
        u.vals = vals;
        m_pend.push_back(u);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    //  name            rst stl fl val op     result      ov q  chk  flags  bsy bst  flags_b bst_b
    v("rst0",           0, 0, 0, 1, 4'h0, 16'h0000, 0, 0, 0, 3'b000, 0, 0, 3'b000, 0);
    v("rst1",           0, 0, 0, 1, 4'h0, 16'h0000, 0, 0, 1, 3'b000, 0, 0, 3'b000, 0);
    v("post_rst",       1, 0, 0, 0, 4'h0, 16'h0000, 0, 0, 1, 3'b000, 0, 0, 3'b000, 0);
    v("sub_cap",        1, 0, 0, 1, 4'h1, 16'h8000, 1, 0, 1, 3'b000, 0, 0, 3'b000, 0);
    v("sub_busy",       1, 0, 0, 0, 4'h0, 16'h0000, 0, 0, 1, 3'b000, 1, 0, 3'b011, 0);
    v("sub_commit",     1, 0, 0, 0, 4'h0, 16'h0000, 0, 0, 1, 3'b011, 0, 0, 3'b011, 0);
    v("add0",           1, 0, 0, 1, 4'h0, 16'h0000, 0, 0, 1, 3'b011, 0, 0, 3'b011, 0);
    v("xor5",           1, 0, 0, 1, 4'h2, 16'h0005, 0, 0, 1, 3'b011, 1, 0, 3'b100, 0);
    v("sll0",           1, 0, 0, 1, 4'h4, 16'h0000, 0, 0, 1, 3'b100, 1, 0, 3'b000, 0);
    v("sll_busy",       1, 0, 0, 0, 4'h0, 16'h0000, 0, 0, 1, 3'b000, 1, 0, 3'b100, 0);
    v("sll_commit",     1, 0, 0, 0, 4'h0, 16'h0000, 0, 0, 1, 3'b100, 0, 0, 3'b100, 0);
    v("fl_add",         1, 0, 0, 1, 4'h0, 16'h0000, 1, 0, 1, 3'b100, 0, 0, 3'b100, 0);
    v("flush",          1, 0, 1, 0, 4'h0, 16'h0000, 0, 0, 1, 3'b100, 1, 0, 3'b110, 0);
    v("fl_after",       1, 0, 0, 0, 4'h0, 16'h0000, 0, 0, 1, 3'b100, 0, 0, 3'b100, 0);
    v("fl_block",       1, 0, 1, 1, 4'h0, 16'h1234, 0, 1, 1, 3'b100, 0, 1, 3'b100, 1);
    v("fl_block_after", 1, 0, 0, 0, 4'h0, 16'h0000, 0, 1, 1, 3'b100, 0, 0, 3'b100, 0);
    v("fs_add",         1, 0, 0, 1, 4'h0, 16'h8000, 0, 0, 1, 3'b100, 0, 0, 3'b100, 0);
    v("fs_flush_stall", 1, 1, 1, 0, 4'h0, 16'h0000, 0, 0, 1, 3'b100, 1, 0, 3'b001, 0);
    v("fs_after",       1, 0, 0, 0, 4'h0, 16'h0000, 0, 0, 1, 3'b100, 0, 0, 3'b100, 0);
    v("st_t",           1, 0, 0, 1, 4'h0, 16'hFFFF, 1, 1, 1, 3'b100, 0, 1, 3'b100, 1);
    v("st_t1",          1, 1, 0, 0, 4'h0, 16'h0000, 0, 1, 1, 3'b100, 1, 1, 3'b011, 0);
    v("st_t2",          1, 1, 0, 0, 4'h0, 16'h0000, 0, 1, 1, 3'b100, 1, 1, 3'b011, 0);
    v("st_t3",          1, 0, 0, 0, 4'h0, 16'h0000, 0, 1, 1, 3'b100, 1, 1, 3'b011, 0);
    v("st_done",        1, 0, 0, 0, 4'h0, 16'h0000, 0, 1, 1, 3'b011, 0, 0, 3'b011, 0);
    v("paddsb",         1, 0, 0, 1, 4'h7, 16'h0000, 0, 1, 1, 3'b011, 0, 0, 3'b011, 0);
    v("paddsb_after",   1, 0, 0, 0, 4'h0, 16'h0000, 0, 1, 1, 3'b011, 0, 0, 3'b011, 0);

    drive(0, 0, 0, 0, 4'h0, '0, 0, 0);
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].stall, vecs[i].flush, vecs[i].valid,
            vecs[i].op, vecs[i].res, vecs[i].ovfl, vecs[i].q);
      @(negedge clk);
      if (vecs[i].chk) begin
`ifdef FLAG_BYPASS_EN
        check({vecs[i].name, "_flags"}, flags, vecs[i].efb);
        check({vecs[i].name, "_br_stall"}, {2'b00, br_stall}, {2'b00, vecs[i].esb});
`else
        check({vecs[i].name, "_flags"}, flags, vecs[i].ef);
        check({vecs[i].name, "_br_stall"}, {2'b00, br_stall}, {2'b00, vecs[i].es});
`endif
        check({vecs[i].name, "_busy"}, {2'b00, flags_busy}, {2'b00, vecs[i].eb});
      end
      model_cycle(1'b0);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 2000; i++) begin
      logic [WIDTH-1:0] res;
      case ($urandom_range(3))
        0:       res = '0;
        1:       res = 16'h8000;
        default: res = WIDTH'($urandom);
      endcase
      drive(($urandom_range(49) != 0), ($urandom_range(4) == 0), ($urandom_range(9) == 0),
            ($urandom_range(9) < 7), 4'($urandom_range(15)), res,
            1'($urandom_range(1)), 1'($urandom_range(1)));
      @(negedge clk);
      model_cycle(1'b1);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
